// File: rtl/up_counter_pkg.sv
// Shared types and default sizing for the up_counter block.
package up_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_MAX   = 7;

endpackage

// File: rtl/up_counter.sv
// up_counter: start/enable/load controlled up-counter with terminal-count pulse.
// Optional feature macro: UP_COUNTER_WRAP_EN
//   undefined -> saturate at MAX in DONE until start, load or rst
//   defined   -> wrap MAX -> 0 and keep counting; DONE reachable only by load
module up_counter
    import up_counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX   = DEF_MAX
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_C  = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] MAX_M1 = WIDTH'(MAX - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] ld_sat;

    // Loaded value clamped so count can never exceed MAX.
    assign ld_sat = (load_val > MAX_C) ? MAX_C : load_val;

    // State, count and done registers; reset aborts any run and pending pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: load beats start/en; done only on arrival at MAX by incrementing.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        done_d  = 1'b0;
        if (load) begin
            count_d = ld_sat;
            state_d = (ld_sat < MAX_C) ? COUNT : DONE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        count_d = '0;
                        state_d = COUNT;
                    end
                end
                COUNT: begin
                    if (en) begin
`ifdef UP_COUNTER_WRAP_EN
                        // Wrapping mode stays in COUNT; MAX is held for one enabled cycle.
                        if (count_q == MAX_C) begin
                            count_d = '0;
                        end else if (count_q == MAX_M1) begin
                            count_d = MAX_C;
                            done_d  = 1'b1;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
`else
                        // >= guards against ever stepping past MAX.
                        if (count_q >= MAX_M1) begin
                            count_d = MAX_C;
                            done_d  = 1'b1;
                            state_d = DONE;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign count = count_q;
    assign busy  = (state_q == COUNT);
    assign done  = done_q;

endmodule

// File: tb/tb_up_counter.sv
// Directed self-checking bench for up_counter (WIDTH=3, MAX=7).
// Build with +define+UP_COUNTER_WRAP_EN to exercise the wrapping variant.
module tb_up_counter;

    logic       clk;
    logic       rst;
    logic       start;
    logic       en;
    logic       load;
    logic [2:0] load_val;
    logic [2:0] count;
    logic       busy;
    logic       done;

    int n_pass  = 0;
    int n_total = 0;

    up_counter #(.WIDTH(3), .MAX(7)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Async reset pulse placed between clock edges.
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #1 rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; en = 1'b0; load = 1'b0; load_val = 3'd0;

        // Reset state, before any clock edge
        #2;
        chk("rst_count", int'(count), 0);
        chk("rst_busy",  int'(busy),  0);
        chk("rst_done",  int'(done),  0);
        #1 rst = 1'b0;
        #1;
        chk("rel_count", int'(count), 0);
        chk("rel_busy",  int'(busy),  0);
        chk("rel_done",  int'(done),  0);

        // Start from IDLE, then count with en held
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_count", int'(count), 0);
        chk("start_busy",  int'(busy),  1);
        chk("start_done",  int'(done),  0);
        en = 1'b1;
`ifdef UP_COUNTER_WRAP_EN
        // 20 enabled cycles total counting the start cycle as cycle 0
        for (int i = 1; i < 20; i++) begin
            step();
            chk($sformatf("wrap_count_%0d", i), int'(count), i % 8);
            chk($sformatf("wrap_done_%0d", i),  int'(done),  (i % 8 == 7) ? 1 : 0);
            chk($sformatf("wrap_busy_%0d", i),  int'(busy),  1);
        end
`else
        for (int k = 1; k <= 7; k++) begin
            step();
            chk($sformatf("run_count_%0d", k), int'(count), k);
            chk($sformatf("run_done_%0d", k),  int'(done),  (k == 7) ? 1 : 0);
            chk($sformatf("run_busy_%0d", k),  int'(busy),  (k == 7) ? 0 : 1);
        end
        step();
        chk("sat_count", int'(count), 7);
        chk("sat_done",  int'(done),  0);
        chk("sat_busy",  int'(busy),  0);
        step();
        chk("sat2_count", int'(count), 7);
        chk("sat2_done",  int'(done),  0);
`endif

        // en toggled 1,0,1 from count=3
        en = 1'b0;
        pulse_rst();
        chk("rst2_count", int'(count), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        en = 1'b1;
        step(); step(); step();
        chk("pre_tog_count", int'(count), 3);
        step();
        chk("tog1_count", int'(count), 4);
        en = 1'b0;
        step();
        chk("tog0_count", int'(count), 4);
        chk("tog0_done",  int'(done),  0);
        chk("tog0_busy",  int'(busy),  1);
        en = 1'b1;
        step();
        chk("tog1b_count", int'(count), 5);
        step();
        chk("pre_load_count", int'(count), 6);

        // Load in COUNT beats start and en
        load = 1'b1; load_val = 3'd5; start = 1'b1;
        step();
        load = 1'b0; start = 1'b0; en = 1'b0;
        chk("load5_count", int'(count), 5);
        chk("load5_busy",  int'(busy),  1);
        chk("load5_done",  int'(done),  0);
        step();
        chk("load5_hold", int'(count), 5);
        load = 1'b1; load_val = 3'd7; en = 1'b1;
        step();
        load = 1'b0; en = 1'b0;
        chk("load7_count", int'(count), 7);
        chk("load7_busy",  int'(busy),  0);
        chk("load7_done",  int'(done),  0);
        step();
        chk("load7_done2", int'(done), 0);
        chk("load7_hold",  int'(count), 7);

        // Load below MAX from DONE returns to COUNT; run on to MAX pulses done
        load = 1'b1; load_val = 3'd3;
        step();
        load = 1'b0;
        chk("load3_count", int'(count), 3);
        chk("load3_busy",  int'(busy),  1);
        en = 1'b1;
        for (int k = 4; k <= 7; k++) begin
            step();
            chk($sformatf("l3run_count_%0d", k), int'(count), k);
            chk($sformatf("l3run_done_%0d", k),  int'(done),  (k == 7) ? 1 : 0);
        end
        en = 1'b0;

        // Reset mid-run at count=6
        pulse_rst();
        start = 1'b1;
        step();
        start = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        chk("pre_rst_count", int'(count), 6);
        #2 rst = 1'b1;
        #1;
        chk("midrst_count", int'(count), 0);
        chk("midrst_busy",  int'(busy),  0);
        chk("midrst_done",  int'(done),  0);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("postrst_count_%0d", k), int'(count), 0);
            chk($sformatf("postrst_done_%0d", k),  int'(done),  0);
            chk($sformatf("postrst_busy_%0d", k),  int'(busy),  0);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_busy",  int'(busy),  1);
        chk("restart_count", int'(count), 0);
        step();
        chk("restart_inc", int'(count), 1);
        en = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
